// File: rtl/fetch_sequencer.sv
// Fetch-stage sequencer: owns the fetch PC, drives the instruction ROM and buffers returned words for decode.
// Optional build macro FETCH_PERF_CNT_EN adds the perf_fetched / perf_stall counters.
module fetch_sequencer #(
  parameter int ADDR_W   = 6,
  parameter int DATA_W   = 32,
  parameter int PROG_LEN = 12,
  parameter int RESET_PC = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [DATA_W-1:0] inst_data,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              busy,
  output logic              halted
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]       perf_fetched,
  output logic [31:0]       perf_stall
`endif
);

  localparam logic [ADDR_W-1:0] LP_END   = ADDR_W'(PROG_LEN);
  localparam logic [ADDR_W-1:0] LP_RESET = ADDR_W'(RESET_PC);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_HALT} state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_fetch_pc;
  logic [1:0]        r_count;
  logic              r_busy;
  logic              r_halted;
  logic [DATA_W-1:0] r_buf_data [2];
  logic [ADDR_W-1:0] r_buf_pc   [2];

  logic              w_pop;
  logic              w_issue;
  logic              w_redirect;
  logic              w_pc_done;
  logic [1:0]        w_count_after_pop;

  // Redirect is ignored in IDLE; issue needs buffer space (or a same-cycle pop).
  assign w_redirect        = redirect_valid && (r_state != S_IDLE);
  assign w_pc_done         = (r_fetch_pc >= LP_END);
  assign w_pop             = inst_valid && inst_ready;
  assign w_issue           = (r_state == S_FETCH) && !w_pc_done &&
                             ((r_count < 2'd2) || w_pop) && !redirect_valid;
  assign w_count_after_pop = r_count - {1'b0, w_pop};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_fetch_pc <= LP_RESET;
      r_count    <= 2'd0;
      r_busy     <= 1'b0;
      r_halted   <= 1'b0;
    end else if (w_redirect) begin
      r_state    <= S_FETCH;
      r_fetch_pc <= redirect_pc;
      r_count    <= 2'd0;
      r_busy     <= 1'b1;
      r_halted   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state    <= S_FETCH;
            r_fetch_pc <= LP_RESET;
            r_busy     <= 1'b1;
          end
        end
        S_FETCH: begin
          r_count <= w_count_after_pop + {1'b0, w_issue};
          if (w_issue) begin
            r_fetch_pc <= r_fetch_pc + ADDR_W'(1);
          end
          if (w_pc_done && (w_count_after_pop == 2'd0)) begin
            r_state  <= S_HALT;
            r_busy   <= 1'b0;
            r_halted <= 1'b1;
          end
        end
        default: begin
          r_state <= S_HALT;
        end
      endcase
    end
  end

  // Head lives in entry 0; a pop shifts entry 1 down, a push fills the first free slot.
  always_ff @(posedge clk) begin
    if (w_issue) begin
      if (w_pop && (r_count == 2'd2)) begin
        r_buf_data[0] <= r_buf_data[1];
        r_buf_pc[0]   <= r_buf_pc[1];
        r_buf_data[1] <= rom_data;
        r_buf_pc[1]   <= r_fetch_pc;
      end else if (w_pop) begin
        r_buf_data[0] <= rom_data;
        r_buf_pc[0]   <= r_fetch_pc;
      end else begin
        r_buf_data[r_count[0]] <= rom_data;
        r_buf_pc[r_count[0]]   <= r_fetch_pc;
      end
    end else if (w_pop) begin
      r_buf_data[0] <= r_buf_data[1];
      r_buf_pc[0]   <= r_buf_pc[1];
    end
  end

  assign rom_addr   = r_fetch_pc;
  assign inst_valid = (r_count != 2'd0);
  assign inst_data  = inst_valid ? r_buf_data[0] : '0;
  assign inst_pc    = inst_valid ? r_buf_pc[0] : '0;
  assign busy       = r_busy;
  assign halted     = r_halted;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] r_perf_fetched;
  logic [31:0] r_perf_stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_fetched <= '0;
      r_perf_stall   <= '0;
    end else begin
      if (w_pop && !(&r_perf_fetched)) begin
        r_perf_fetched <= r_perf_fetched + 32'd1;
      end
      if ((r_state == S_FETCH) && inst_valid && !inst_ready && !(&r_perf_stall)) begin
        r_perf_stall <= r_perf_stall + 32'd1;
      end
    end
  end

  assign perf_fetched = r_perf_fetched;
  assign perf_stall   = r_perf_stall;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: streaming, back-pressure, redirect, halt and mid-stream reset.
module tb_fetch_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        redirect_valid;
  logic [5:0]  redirect_pc;
  logic [5:0]  rom_addr;
  logic [31:0] rom_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [5:0]  inst_pc;
  logic        busy;
  logic        halted;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_stall;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  fetch_sequencer #(.ADDR_W(6), .DATA_W(32), .PROG_LEN(12), .RESET_PC(0)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .rom_addr       (rom_addr),
    .rom_data       (rom_data),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc),
    .busy           (busy),
    .halted         (halted)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetched   (perf_fetched),
    .perf_stall     (perf_stall)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [5:0] a);
    return 32'h1357_0000 + ({26'b0, a} * 32'h0001_0011);
  endfunction

  // ROM samples the address on the falling edge.
  always @(negedge clk) rom_data = rom_word(rom_addr);

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; start = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    step(); step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; inst_ready = 1'b0;
    step(); step();
    n_cmp++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", inst_valid); end
    n_cmp++; if (inst_data !== 32'h0) begin n_fail++; $display("FAIL reset_data: got %h want 0", inst_data); end
    n_cmp++; if (inst_pc !== 6'd0) begin n_fail++; $display("FAIL reset_pc: got %0d want 0", inst_pc); end
    n_cmp++; if (busy !== 1'b0 || halted !== 1'b0) begin n_fail++; $display("FAIL reset_state: got busy=%b halted=%b want 0 0", busy, halted); end
    n_cmp++; if (rom_addr !== 6'd0) begin n_fail++; $display("FAIL reset_rom_addr: got %0d want 0", rom_addr); end
    rst_n = 1'b1;
    step();
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_no_start: got busy=%b want 0", busy); end
  endtask

  task automatic test_stream();
    do_reset();
    inst_ready = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    n_cmp++; if (busy !== 1'b1 || rom_addr !== 6'd0 || inst_valid !== 1'b0) begin
      n_fail++; $display("FAIL stream_first_cycle: got busy=%b addr=%0d valid=%b want 1 0 0", busy, rom_addr, inst_valid);
    end
    step();
    for (int i = 0; i < 12; i++) begin
      n_cmp++; if (inst_valid !== 1'b1 || inst_pc !== i[5:0] || inst_data !== rom_word(i[5:0])) begin
        n_fail++; $display("FAIL stream_head[%0d]: got valid=%b pc=%0d data=%h want 1 %0d %h", i, inst_valid, inst_pc, inst_data, i, rom_word(i[5:0]));
      end
      step();
    end
    n_cmp++; if (halted !== 1'b1 || busy !== 1'b0 || inst_valid !== 1'b0 || rom_addr !== 6'd12) begin
      n_fail++; $display("FAIL stream_halt: got halted=%b busy=%b valid=%b addr=%0d want 1 0 0 12", halted, busy, inst_valid, rom_addr);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    inst_ready = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 5; k++) step();
    n_cmp++; if (rom_addr !== 6'd2 || inst_valid !== 1'b1 || inst_pc !== 6'd0 || inst_data !== rom_word(6'd0)) begin
      n_fail++; $display("FAIL bp_stall: got addr=%0d valid=%b pc=%0d data=%h want 2 1 0 %h", rom_addr, inst_valid, inst_pc, inst_data, rom_word(6'd0));
    end
    inst_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      n_cmp++; if (inst_valid !== 1'b1 || inst_pc !== i[5:0] || inst_data !== rom_word(i[5:0])) begin
        n_fail++; $display("FAIL bp_release[%0d]: got valid=%b pc=%0d data=%h want 1 %0d %h", i, inst_valid, inst_pc, inst_data, i, rom_word(i[5:0]));
      end
      step();
    end
    n_cmp++; if (halted !== 1'b1 || inst_valid !== 1'b0) begin
      n_fail++; $display("FAIL bp_halt: got halted=%b valid=%b want 1 0", halted, inst_valid);
    end
  endtask

  task automatic test_redirect();
    do_reset();
    inst_ready = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 4; k++) step();
    n_cmp++; if (inst_pc !== 6'd3) begin n_fail++; $display("FAIL rd_setup_head: got %0d want 3", inst_pc); end
    inst_ready = 1'b0;
    step();
    n_cmp++; if (inst_pc !== 6'd3 || rom_addr !== 6'd5) begin
      n_fail++; $display("FAIL rd_setup_buf: got pc=%0d addr=%0d want 3 5", inst_pc, rom_addr);
    end
    redirect_valid = 1'b1; redirect_pc = 6'd8; inst_ready = 1'b1;
    step();
    redirect_valid = 1'b0;
    n_cmp++; if (inst_valid !== 1'b0 || rom_addr !== 6'd8) begin
      n_fail++; $display("FAIL rd_flush: got valid=%b addr=%0d want 0 8", inst_valid, rom_addr);
    end
    step();
    for (int i = 8; i < 12; i++) begin
      n_cmp++; if (inst_valid !== 1'b1 || inst_pc !== i[5:0] || inst_data !== rom_word(i[5:0])) begin
        n_fail++; $display("FAIL rd_target[%0d]: got valid=%b pc=%0d data=%h want 1 %0d %h", i, inst_valid, inst_pc, inst_data, i, rom_word(i[5:0]));
      end
      step();
    end
    n_cmp++; if (halted !== 1'b1) begin n_fail++; $display("FAIL rd_halt: got %b want 1", halted); end
  endtask

  task automatic test_halt_redirect();
    start = 1'b1;
    step();
    start = 1'b0;
    n_cmp++; if (halted !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL halt_ignores_start: got halted=%b busy=%b want 1 0", halted, busy);
    end
    redirect_valid = 1'b1; redirect_pc = 6'd2;
    step();
    redirect_valid = 1'b0;
    n_cmp++; if (busy !== 1'b1 || halted !== 1'b0 || inst_valid !== 1'b0 || rom_addr !== 6'd2) begin
      n_fail++; $display("FAIL hr_enter: got busy=%b halted=%b valid=%b addr=%0d want 1 0 0 2", busy, halted, inst_valid, rom_addr);
    end
    step();
    for (int i = 2; i < 12; i++) begin
      n_cmp++; if (inst_valid !== 1'b1 || inst_pc !== i[5:0] || inst_data !== rom_word(i[5:0])) begin
        n_fail++; $display("FAIL hr_stream[%0d]: got valid=%b pc=%0d data=%h want 1 %0d %h", i, inst_valid, inst_pc, inst_data, i, rom_word(i[5:0]));
      end
      step();
    end
    n_cmp++; if (halted !== 1'b1) begin n_fail++; $display("FAIL hr_rehalt: got %b want 1", halted); end
    redirect_valid = 1'b1; redirect_pc = 6'd20;
    step();
    redirect_valid = 1'b0;
    n_cmp++; if (busy !== 1'b1 || inst_valid !== 1'b0 || rom_addr !== 6'd20) begin
      n_fail++; $display("FAIL hr_oob_fetch: got busy=%b valid=%b addr=%0d want 1 0 20", busy, inst_valid, rom_addr);
    end
    step();
    n_cmp++; if (halted !== 1'b1 || inst_valid !== 1'b0 || rom_addr !== 6'd20) begin
      n_fail++; $display("FAIL hr_oob_halt: got halted=%b valid=%b addr=%0d want 1 0 20", halted, inst_valid, rom_addr);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    inst_ready = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    step(); step(); step();
    n_cmp++; if (inst_valid !== 1'b1 || rom_addr !== 6'd2) begin
      n_fail++; $display("FAIL rm_full: got valid=%b addr=%0d want 1 2", inst_valid, rom_addr);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (inst_valid !== 1'b0 || inst_data !== 32'h0 || inst_pc !== 6'd0 || rom_addr !== 6'd0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL rm_async: got valid=%b data=%h pc=%0d addr=%0d busy=%b want 0 0 0 0 0", inst_valid, inst_data, inst_pc, rom_addr, busy);
    end
    step();
    rst_n = 1'b1;
    inst_ready = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    n_cmp++; if (inst_valid !== 1'b1 || inst_pc !== 6'd0 || inst_data !== rom_word(6'd0)) begin
      n_fail++; $display("FAIL rm_restart: got valid=%b pc=%0d data=%h want 1 0 %h", inst_valid, inst_pc, inst_data, rom_word(6'd0));
    end
  endtask

`ifdef FETCH_PERF_CNT_EN
  task automatic test_perf();
    do_reset();
    n_cmp++; if (perf_fetched !== 32'd0 || perf_stall !== 32'd0) begin
      n_fail++; $display("FAIL perf_reset: got fetched=%0d stall=%0d want 0 0", perf_fetched, perf_stall);
    end
    inst_ready = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    for (int k = 0; k < 20; k++) begin
      inst_ready = !(k == 3 || k == 6 || k == 10);
      step();
    end
    n_cmp++; if (perf_fetched !== 32'd12 || perf_stall !== 32'd3) begin
      n_fail++; $display("FAIL perf_counts: got fetched=%0d stall=%0d want 12 3", perf_fetched, perf_stall);
    end
  endtask
`endif

  initial begin
    rst_n = 1'b0; start = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; inst_ready = 1'b0;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_halt_redirect();
    test_reset_mid();
`ifdef FETCH_PERF_CNT_EN
    test_perf();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
